spi_txn_ctrl: RTL and testbench

Transaction sequencer in front of the byte-level SPI master. It owns the active-low chip select and runs a multi-byte transaction of 1..MAX_BYTES bytes. It feeds TX bytes from a valid/ready user stream into the master, forwards received bytes, and enforces CS setup, hold and minimum-deassert timing. It sits between the host/register logic and SPI_Master, one instance per SPI bus.

---
 rtl/spi_pkg.sv | 25 ++
 rtl/spi_cs_timer.sv | 35 +++
 rtl/spi_txn_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_spi_txn_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared encodings and default chip-select timing for the SPI transaction sequencer
// and the register wrapper that configures it.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETUP     = 3'd1,
        ST_WAIT_DATA = 3'd2,
        ST_WAIT_BYTE = 3'd3,
        ST_HOLD      = 3'd4,
        ST_GAP       = 3'd5
    } txn_state_e;

    localparam int MAX_BYTES_DEF     = 256;
    localparam int CS_SETUP_CLKS_DEF = 2;
    localparam int CS_HOLD_CLKS_DEF  = 2;
    localparam int CS_IDLE_CLKS_DEF  = 2;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/spi_cs_timer.sv
// Load/count/done down-counter used for the chip-select setup, hold and idle intervals.
// o_Done is high whenever the count has reached zero.
module spi_cs_timer #(
    parameter int CNT_W = 2
) (
    input  logic             i_Clk,
    input  logic             i_Rst_L,
    input  logic             i_Load,
    input  logic [CNT_W-1:0] i_Load_Val,
    output logic             o_Done
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_Load) begin
            count_d = i_Load_Val;
        end else if (count_q != '0) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_Done = (count_q == '0);

endmodule

// File: rtl/spi_txn_ctrl.sv
// SPI transaction sequencer: owns chip select and streams 1..MAX_BYTES bytes through the byte master.
// state     | meaning
// IDLE      | CS high, waiting for a legal start
// SETUP     | CS low, setup time before the first byte
// WAIT_DATA | waiting for a user byte and master ready
// WAIT_BYTE | one byte in flight in the master
// HOLD      | CS still low after the last byte
// GAP       | CS high, minimum deassert time
module spi_txn_ctrl
    import spi_pkg::*;
#(
    parameter int  MAX_BYTES     = MAX_BYTES_DEF,
    parameter int  CS_SETUP_CLKS = CS_SETUP_CLKS_DEF,
    parameter int  CS_HOLD_CLKS  = CS_HOLD_CLKS_DEF,
    parameter int  CS_IDLE_CLKS  = CS_IDLE_CLKS_DEF,
    localparam int LEN_W         = $clog2(MAX_BYTES + 1)
) (
    input  logic             i_Clk,
    input  logic             i_Rst_L,
    input  logic             i_Txn_Start,
    input  logic [LEN_W-1:0] i_Txn_Len,
    output logic             o_Busy,
    output logic             o_Txn_Done,
    input  logic [7:0]       i_TX_Data,
    input  logic             i_TX_Valid,
    output logic             o_TX_Take,
    output logic [7:0]       o_RX_Data,
    output logic             o_RX_Valid,
    output logic [7:0]       o_M_TX_Byte,
    output logic             o_M_TX_DV,
    input  logic             i_M_TX_Ready,
    input  logic             i_M_RX_DV,
    input  logic [7:0]       i_M_RX_Byte,
    output logic             o_SPI_CS_n
);

    localparam int CS_MAX = max3(CS_SETUP_CLKS, CS_HOLD_CLKS, CS_IDLE_CLKS);
    localparam int CNT_W  = $clog2(CS_MAX) + 1;

    // The WAIT_DATA cycle that issues DV counts toward setup, so SETUP itself
    // lasts one cycle less (never below one, since it is a real state).
    localparam int SETUP_LOAD = (CS_SETUP_CLKS > 2) ? CS_SETUP_CLKS - 2 : 0;

    localparam logic [CNT_W-1:0] SETUP_VAL = CNT_W'(SETUP_LOAD);
    localparam logic [CNT_W-1:0] HOLD_VAL  = CNT_W'(CS_HOLD_CLKS - 1);
    localparam logic [CNT_W-1:0] GAP_VAL   = CNT_W'(CS_IDLE_CLKS - 1);
    localparam logic [LEN_W-1:0] MAX_LEN   = LEN_W'(MAX_BYTES);

    txn_state_e       state_q, state_d;
    logic             cs_n_q, cs_n_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             take_q, take_d;
    logic             rx_valid_q, rx_valid_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             m_dv_q, m_dv_d;
    logic [7:0]       m_byte_q, m_byte_d;
    logic [LEN_W-1:0] rem_q, rem_d;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_done;

    spi_cs_timer #(
        .CNT_W (CNT_W)
    ) u_cs_timer (
        .i_Clk      (i_Clk),
        .i_Rst_L    (i_Rst_L),
        .i_Load     (tmr_load),
        .i_Load_Val (tmr_val),
        .o_Done     (tmr_done)
    );

    always_comb begin
        state_d    = state_q;
        cs_n_d     = cs_n_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        take_d     = 1'b0;
        rx_valid_d = 1'b0;
        rx_data_d  = rx_data_q;
        m_dv_d     = 1'b0;
        m_byte_d   = m_byte_q;
        rem_d      = rem_q;
        tmr_load   = 1'b0;
        tmr_val    = '0;

        case (state_q)
            ST_IDLE: begin
                if (i_Txn_Start && (i_Txn_Len != '0) && (i_Txn_Len <= MAX_LEN)) begin
                    rem_d    = i_Txn_Len;
                    cs_n_d   = 1'b0;
                    busy_d   = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = SETUP_VAL;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (tmr_done) begin
                    state_d = ST_WAIT_DATA;
                end
            end
            ST_WAIT_DATA: begin
                if (i_TX_Valid && i_M_TX_Ready) begin
                    m_dv_d   = 1'b1;
                    m_byte_d = i_TX_Data;
                    take_d   = 1'b1;
                    state_d  = ST_WAIT_BYTE;
                end
            end
            ST_WAIT_BYTE: begin
                if (i_M_RX_DV) begin
                    rx_data_d  = i_M_RX_Byte;
                    rx_valid_d = 1'b1;
                    rem_d      = (rem_q != '0) ? rem_q - LEN_W'(1) : '0;
                    if (rem_q <= LEN_W'(1)) begin
                        tmr_load = 1'b1;
                        tmr_val  = HOLD_VAL;
                        state_d  = ST_HOLD;
                    end else begin
                        state_d  = ST_WAIT_DATA;
                    end
                end
            end
            ST_HOLD: begin
                if (tmr_done) begin
                    cs_n_d   = 1'b1;
                    done_d   = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = GAP_VAL;
                    state_d  = ST_GAP;
                end
            end
            ST_GAP: begin
                if (tmr_done) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cs_n_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q    <= ST_IDLE;
            cs_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            take_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= 8'h00;
            m_dv_q     <= 1'b0;
            m_byte_q   <= 8'h00;
            rem_q      <= '0;
        end else begin
            state_q    <= state_d;
            cs_n_q     <= cs_n_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            take_q     <= take_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            m_dv_q     <= m_dv_d;
            m_byte_q   <= m_byte_d;
            rem_q      <= rem_d;
        end
    end

    assign o_SPI_CS_n  = cs_n_q;
    assign o_Busy      = busy_q;
    assign o_Txn_Done  = done_q;
    assign o_TX_Take   = take_q;
    assign o_RX_Valid  = rx_valid_q;
    assign o_RX_Data   = rx_data_q;
    assign o_M_TX_DV   = m_dv_q;
    assign o_M_TX_Byte = m_byte_q;

endmodule

// File: tb/tb_spi_txn_ctrl.sv
// Bench for spi_txn_ctrl: behavioural byte master, user byte source and a monitor
// that timestamps CS/DV/RX/Done/Busy events against the expected chip-select timing.
module tb_spi_txn_ctrl;

    localparam int MAXB    = 256;
    localparam int LW      = 9;
    localparam int T_SETUP = 2;
    localparam int T_HOLD  = 2;
    localparam int T_IDLE  = 2;

    logic          clk = 1'b0;
    logic          rst_l;
    logic          start;
    logic [LW-1:0] txn_len;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          m_ready;
    logic          m_rx_dv;
    logic [7:0]    m_rx_byte;

    logic          o_Busy, o_Txn_Done, o_TX_Take, o_RX_Valid, o_M_TX_DV, o_SPI_CS_n;
    logic [7:0]    o_RX_Data, o_M_TX_Byte;

    always #5 clk = ~clk;

    spi_txn_ctrl #(
        .MAX_BYTES     (MAXB),
        .CS_SETUP_CLKS (T_SETUP),
        .CS_HOLD_CLKS  (T_HOLD),
        .CS_IDLE_CLKS  (T_IDLE)
    ) dut (
        .i_Clk        (clk),
        .i_Rst_L      (rst_l),
        .i_Txn_Start  (start),
        .i_Txn_Len    (txn_len),
        .o_Busy       (o_Busy),
        .o_Txn_Done   (o_Txn_Done),
        .i_TX_Data    (tx_data),
        .i_TX_Valid   (tx_valid),
        .o_TX_Take    (o_TX_Take),
        .o_RX_Data    (o_RX_Data),
        .o_RX_Valid   (o_RX_Valid),
        .o_M_TX_Byte  (o_M_TX_Byte),
        .o_M_TX_DV    (o_M_TX_DV),
        .i_M_TX_Ready (m_ready),
        .i_M_RX_DV    (m_rx_dv),
        .i_M_RX_Byte  (m_rx_byte),
        .o_SPI_CS_n   (o_SPI_CS_n)
    );

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- monitor ----------------
    int cyc, n_take, n_rxv, n_done, n_dv, n_cs_fall, n_cs_rise, n_busy_hi;
    int cs_fall_c, cs_rise_c, last_rxv_c, done_c, busy_fall_c;
    int dv_c[$];
    logic [7:0] rx_got[$];
    logic prev_cs, prev_busy;

    task automatic clear_mon();
        n_take = 0; n_rxv = 0; n_done = 0; n_dv = 0;
        n_cs_fall = 0; n_cs_rise = 0; n_busy_hi = 0;
        cs_fall_c = -1; cs_rise_c = -1; last_rxv_c = -1; done_c = -1; busy_fall_c = -1;
        dv_c.delete();
        rx_got.delete();
    endtask

    initial begin
        cyc = 0; prev_cs = 1'b1; prev_busy = 1'b0;
        clear_mon();
        forever begin
            @(negedge clk);
            cyc++;
            if (o_TX_Take) n_take++;
            if (o_RX_Valid) begin n_rxv++; last_rxv_c = cyc; rx_got.push_back(o_RX_Data); end
            if (o_Txn_Done) begin n_done++; done_c = cyc; end
            if (o_M_TX_DV) begin n_dv++; dv_c.push_back(cyc); end
            if (o_Busy) n_busy_hi++;
            if (prev_cs && !o_SPI_CS_n) begin n_cs_fall++; cs_fall_c = cyc; end
            if (!prev_cs && o_SPI_CS_n) begin n_cs_rise++; cs_rise_c = cyc; end
            if (prev_busy && !o_Busy) busy_fall_c = cyc;
            prev_cs = o_SPI_CS_n;
            prev_busy = o_Busy;
        end
    end

    // ---------------- user byte source ----------------
    logic [7:0] tx_src[$];
    int stall_len, stall_cnt;
    bit stall_arm;

    initial begin
        tx_valid = 1'b0; tx_data = 8'h00; stall_cnt = 0;
        forever begin
            @(negedge clk);
            if (o_TX_Take && tx_src.size() > 0) begin
                void'(tx_src.pop_front());
                if (stall_arm) begin stall_arm = 1'b0; stall_cnt = stall_len; end
            end
            if (stall_cnt > 0) begin
                tx_valid = 1'b0;
                stall_cnt--;
            end else begin
                tx_valid = (tx_src.size() > 0);
                if (tx_src.size() > 0) tx_data = tx_src[0];
            end
        end
    end

    // ---------------- behavioural byte master ----------------
    bit m_out, stray_req;
    int m_cnt, proto_err, lat_lo, lat_hi;
    logic [7:0] m_byte, m_xor;
    logic [7:0] m_got[$];

    initial begin
        m_ready = 1'b1; m_rx_dv = 1'b0; m_rx_byte = 8'h00;
        m_out = 1'b0; m_cnt = 0; proto_err = 0;
        forever begin
            @(negedge clk);
            m_rx_dv = 1'b0;
            if (!rst_l) begin
                m_out = 1'b0;
                m_ready = 1'b1;
            end else if (o_M_TX_DV) begin
                if (m_out || o_SPI_CS_n) proto_err++;
                m_out = 1'b1;
                m_ready = 1'b0;
                m_byte = o_M_TX_Byte;
                m_got.push_back(o_M_TX_Byte);
                m_cnt = $urandom_range(lat_hi, lat_lo);
            end else if (m_out) begin
                if (m_cnt == 0) begin
                    m_rx_dv = 1'b1;
                    m_rx_byte = m_byte ^ m_xor;
                    m_out = 1'b0;
                    m_ready = 1'b1;
                end else begin
                    m_cnt--;
                end
            end else if (stray_req) begin
                m_rx_dv = 1'b1;
                m_rx_byte = 8'h3C;
                stray_req = 1'b0;
            end
        end
    end

    // One complete transaction of nb bytes from tx_src, checked against the timing model.
    // overlap_at > 0 fires an extra start that many cycles in, which must be ignored.
    task automatic run_txn(input int nb, input int overlap_at);
        logic [7:0] exp_q[$];
        int b, mism;
        exp_q = tx_src;
        clear_mon();
        m_got.delete();
        txn_len = LW'(nb);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        b = 0;
        while (o_Busy && b < 2000) begin
            start = (b == overlap_at) ? 1'b1 : 1'b0;
            txn_len = (b == overlap_at) ? LW'(1) : txn_len;
            @(negedge clk);
            b++;
        end
        start = 1'b0;
        @(negedge clk);
        check("txn_in_time", (b < 2000), 1);
        check("take_count", n_take, nb);
        check("rx_valid_count", n_rxv, nb);
        check("dv_count", n_dv, nb);
        check("done_count", n_done, 1);
        check("cs_fall_count", n_cs_fall, 1);
        check("cs_rise_count", n_cs_rise, 1);
        mism = 0;
        if (m_got.size() != nb || rx_got.size() != nb) mism++;
        else begin
            for (int i = 0; i < nb; i++) begin
                if (m_got[i] !== exp_q[i]) mism++;
                if (rx_got[i] !== (exp_q[i] ^ m_xor)) mism++;
            end
        end
        check("byte_mismatches", mism, 0);
        check("setup_clks", (dv_c.size() > 0) ? dv_c[0] - cs_fall_c : -1, T_SETUP);
        check("hold_clks", cs_rise_c - last_rxv_c, T_HOLD);
        check("done_at_cs_rise", done_c, cs_rise_c);
        check("busy_after_done", busy_fall_c - done_c, T_IDLE);
        check("master_protocol", proto_err, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    initial begin
        int b, prev_rise, nb;
        rst_l = 1'b0; start = 1'b0; txn_len = '0;
        m_xor = 8'h00; lat_lo = 14; lat_hi = 14;
        stall_len = 0; stall_arm = 1'b0; stray_req = 1'b0;
        #12;
        check("reset_cs_n", o_SPI_CS_n, 1);
        check("reset_pulses", {o_Busy, o_Txn_Done, o_TX_Take, o_RX_Valid, o_M_TX_DV}, 0);
        check("reset_data", {o_M_TX_Byte, o_RX_Data}, 0);
        @(negedge clk);
        rst_l = 1'b1;
        tick(3);

        // single byte, loopback
        tx_src.push_back(8'hA5);
        tick(1);
        run_txn(1, 0);

        // three-byte burst
        lat_lo = 3; lat_hi = 9;
        tx_src.push_back(8'h01); tx_src.push_back(8'h02); tx_src.push_back(8'h03);
        tick(1);
        run_txn(3, 0);

        // data stall of 20 cycles after the first byte
        tx_src.push_back(8'h11); tx_src.push_back(8'h22);
        stall_len = 20; stall_arm = 1'b1;
        tick(1);
        run_txn(2, 0);
        check("stall_dv_gap", (dv_c.size() > 1) ? dv_c[1] - dv_c[0] : -1, 21);

        // illegal lengths and stray master RX_DV while idle
        clear_mon();
        txn_len = LW'(0); start = 1'b1; @(negedge clk); start = 1'b0;
        tick(8);
        txn_len = LW'(257); start = 1'b1; @(negedge clk); start = 1'b0;
        tick(8);
        stray_req = 1'b1;
        tick(4);
        check("illegal_len_busy", n_busy_hi, 0);
        check("illegal_len_cs", n_cs_fall, 0);
        check("stray_rx_dv", n_rxv, 0);

        // start during an active transaction is ignored
        m_xor = 8'hFF;
        tx_src.push_back(8'h5C); tx_src.push_back(8'hC5); tx_src.push_back(8'h7E);
        tick(1);
        run_txn(3, 8);
        tick(6);
        check("overlap_no_restart", n_cs_fall, 1);

        // async reset during byte 2 of a 4-byte transaction
        clear_mon();
        lat_lo = 8; lat_hi = 8;
        for (int i = 0; i < 4; i++) tx_src.push_back(8'($urandom));
        tick(1);
        txn_len = LW'(4); start = 1'b1; @(negedge clk); start = 1'b0;
        b = 0;
        while (n_take < 2 && b < 300) begin @(negedge clk); b++; end
        check("reach_byte2", (b < 300), 1);
        tick(2);
        #2 rst_l = 1'b0;
        #1;
        check("rst_mid_cs_n", o_SPI_CS_n, 1);
        check("rst_mid_pulses", {o_Busy, o_Txn_Done, o_TX_Take, o_RX_Valid, o_M_TX_DV}, 0);
        tx_src.delete();
        tick(3);
        rst_l = 1'b1;
        tick(3);
        check("rst_mid_no_done", n_done, 0);
        tx_src.push_back(8'h96);
        tick(1);
        run_txn(1, 0);

        // back-to-back: start on the cycle Busy falls
        clear_mon();
        m_xor = 8'h0F; lat_lo = 2; lat_hi = 6;
        tx_src.push_back(8'h31); tx_src.push_back(8'h32); tx_src.push_back(8'h33);
        tick(1);
        txn_len = LW'(2); start = 1'b1; @(negedge clk); start = 1'b0;
        b = 0;
        while (o_Busy && b < 500) begin @(negedge clk); b++; end
        txn_len = LW'(1); start = 1'b1;
        prev_rise = cs_rise_c;
        @(negedge clk);
        start = 1'b0;
        check("b2b_accepted", o_Busy, 1);
        b = 0;
        while (o_Busy && b < 500) begin @(negedge clk); b++; end
        tick(1);
        check("b2b_cs_gap", cs_fall_c - prev_rise, T_IDLE + 1);
        check("b2b_done_count", n_done, 2);
        check("b2b_take_count", n_take, 3);

        // randomized transactions
        lat_lo = 1; lat_hi = 10;
        for (int k = 0; k < 6; k++) begin
            nb = $urandom_range(6, 1);
            m_xor = 8'($urandom);
            for (int i = 0; i < nb; i++) tx_src.push_back(8'($urandom));
            tick(1);
            run_txn(nb, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
